fsab_dma_write_ctrl: RTL
========================

Name: fsab_dma_write_ctrl

Overview:
Streaming DMA write master for FSAB, the write-side counterpart of the existing DMA read controller and tester.
- Accepts 64-bit words from a producer (capture or test source) on a valid/ready port and buffers them in a small FIFO.
- Issues fixed 8-beat FSAB write bursts into a circular memory region.
- Sits as one more requester on an FSABArbiter input, alongside the preload, ic, dc and dmac requesters.

Parameters:
FSAB_DID, 4'h3, device ID driven on dmaw__fsabo_did; responses with this DID are ignored (writes carry no data reply).
FSAB_CREDITS, 2, number of requests outstanding at reset; counter width is 3 bits.
FIFO_DEPTH, 16, word entries in the input buffer; power of two, at least 8.
BURST_LEN, 8, beats per burst; fixed, with 64 bytes per burst.

Ports:
clk  in  1  system clock; all logic runs on it.
rst  in  1  asynchronous, active-high reset.
cfg_enable  in  1  when high, permits new bursts to start.
cfg_base  in  [FSAB_ADDR_HI:0]  region base address; bits [5:0] are ignored and treated as 0.
cfg_bursts  in  16  region size in 64-byte bursts; 0 is treated as 1.
in_valid  in  1  producer word valid.
in_data  in  [FSAB_DATA_HI:0]  producer word (64 bits).
in_ready  out  1  FIFO not full.
dmaw__fsabo_valid  out  1  FSAB beat valid.
dmaw__fsabo_mode  out  [FSAB_REQ_HI:0]  request type.
dmaw__fsabo_did  out  [FSAB_DID_HI:0]  device ID.
dmaw__fsabo_subdid  out  [FSAB_DID_HI:0]  sub-device ID.
dmaw__fsabo_addr  out  [FSAB_ADDR_HI:0]  burst address.
dmaw__fsabo_len  out  [FSAB_LEN_HI:0]  burst length.
dmaw__fsabo_data  out  [FSAB_DATA_HI:0]  beat data.
dmaw__fsabo_mask  out  [FSAB_MASK_HI:0]  byte-enable mask.
dmaw__fsabo_credit  in  1  one-cycle pulse from the arbiter returning one request credit.
wrapped  out  1  one-cycle pulse when the write pointer returns to cfg_base.
overflow  out  1  sticky flag: in_valid was high while in_ready was low. Cleared only by rst.

Behaviour:
- Reset values: all outputs 0 except in_ready = 1. FIFO empty, credits = FSAB_CREDITS, write pointer offset = 0, FSM in IDLE.
- Input port: a word is accepted on a cycle where in_valid & in_ready. Words are written in FIFO order.
- FSM states:
  - IDLE: moves to BURST when cfg_enable, FIFO count ≥ 8 and credits > 0. The transition is registered, so the first beat appears the cycle after the condition holds.
  - BURST: beat counter runs 0..7 and asserts dmaw__fsabo_valid for exactly 8 consecutive cycles. There is no backpressure inside a burst; the credit already reserves arbiter space.
- Every beat:
  - data = FIFO head; the head is popped that cycle;
  - mask = all ones;
  - mode = FSAB_WRITE;
  - did = FSAB_DID; subdid = 0;
  - len = 8;
  - addr = cfg_base + offset*64, held constant across the burst.
- Credit consumed on beat 0. A credit return and a consume in the same cycle leave the count unchanged. A return when the count is already FSAB_CREDITS is a protocol error: the count saturates and a simulation $display fires.
- After beat 7: offset increments. If the new offset ≥ max(cfg_bursts,1), offset returns to 0 and wrapped pulses on that same cycle. FSM goes to IDLE, so there is at least one idle cycle between bursts.
- cfg_enable deasserted mid-burst: the burst completes, then no new burst starts. Offset is retained.
- cfg_base and cfg_bursts are sampled each cycle; software changes them only while disabled and idle.
- FIFO full and push-while-pop: a push is accepted whenever count < FIFO_DEPTH, so a simultaneous pop at full does not admit the push (in_ready is registered-free combinational of count).
- rst mid-burst: valid drops asynchronously, the partial burst is abandoned and the FIFO is flushed. The arbiter must be reset by the same reset.

Decomposition:
- Use existing fsab_defines.vh for FSAB_*_HI widths and FSAB_WRITE.
- Add FSAB_BURST_BYTES = 64 to the shared defines.
- One sub-module: fsab_dma_wfifo, a synchronous FIFO with count output and parameters width/depth. Also reusable by the read side.

Test Plan:
- Push 8 words 0x1..0x8, base 0x1000, bursts 4, enable → one burst of 8 beats, addr 0x1000, data 0x1..0x8 in order, len 8, mask 0xFF, credits 2→1.
- Push 24 words with no credit returns → exactly 2 bursts (0x1000, 0x1040); the third waits. A credit pulse then starts the third burst at 0x1080.
- bursts=2, push 24 words with credits returned → addrs 0x1000, 0x1040, 0x1000; wrapped pulses once, after the second burst.
- Hold in_valid with enable=0 → in_ready falls after 16 words; the 17th attempt sets overflow=1, which stays set.
- Deassert enable during beat 3 → beats 4..7 still issued, then no further valid.
- Assert rst during beat 5 → valid=0 in the same cycle, in_ready=1, credits=2; a fresh burst after reset starts at cfg_base.

Source files
------------

// File: rtl/fsab_dma_write_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fsab_dma_write_ctrl_pkg
// Shared FSAB field widths, request encodings and helpers for the DMA write
// master and its input FIFO.
// -----------------------------------------------------------------------------
package fsab_dma_write_ctrl_pkg;

    localparam int FSAB_REQ_HI  = 0;
    localparam int FSAB_DID_HI  = 3;
    localparam int FSAB_ADDR_HI = 30;
    localparam int FSAB_LEN_HI  = 3;
    localparam int FSAB_DATA_HI = 63;
    localparam int FSAB_MASK_HI = 7;

    localparam logic [FSAB_REQ_HI:0] FSAB_READ  = 1'b0;
    localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1'b1;

    localparam int FSAB_BURST_BYTES = 64;
    localparam int BURST_LEN        = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wr_state_t;

    // A region of zero bursts behaves as a single-burst region.
    function automatic logic [15:0] burst_limit(input logic [15:0] bursts);
        return (bursts == 16'd0) ? 16'd1 : bursts;
    endfunction

endpackage

// File: rtl/fsab_dma_wfifo.sv
// -----------------------------------------------------------------------------
// fsab_dma_wfifo
// Synchronous FIFO with occupancy count, shared by the DMA read and write sides.
// A push is taken whenever the FIFO is not full, even if a pop happens in the
// same cycle, so a full FIFO never admits a word.
//
// Ports
//   clk, rst   clock, async active-high reset (flushes pointers and count)
//   i_push     write request, i_data written when not full
//   i_pop      read request, head advances when not empty
//   o_data     current head word (combinational)
//   o_count    number of stored words, 0..DEPTH
//   o_full     count == DEPTH
//   o_empty    count == 0
// -----------------------------------------------------------------------------
module fsab_dma_wfifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fsab_dma_write_ctrl.sv
// -----------------------------------------------------------------------------
// fsab_dma_write_ctrl
// Streaming FSAB DMA write master. Buffers producer words and writes them as
// fixed 8-beat bursts into a circular region starting at cfg_base.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for enable, >= 8 buffered words and a free credit
// ST_BURST | issuing beats 0..7, one FIFO pop per beat, no backpressure
//
// Ports
//   clk, rst              clock, async active-high reset
//   cfg_enable            permits new bursts to start
//   cfg_base              region base (bits [5:0] ignored)
//   cfg_bursts            region size in 64-byte bursts (0 acts as 1)
//   in_valid/in_data      producer word, in_ready = FIFO not full
//   dmaw__fsabo_*         FSAB request channel towards the arbiter
//   dmaw__fsabo_credit    credit return pulse from the arbiter
//   wrapped               pulse when the write offset returns to 0
//   overflow              sticky: producer offered a word while not ready
// -----------------------------------------------------------------------------
module fsab_dma_write_ctrl
    import fsab_dma_write_ctrl_pkg::*;
#(
    parameter logic [FSAB_DID_HI:0] FSAB_DID     = 4'h3,
    parameter int                   FSAB_CREDITS = 2,
    parameter int                   FIFO_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_enable,
    input  logic [FSAB_ADDR_HI:0] cfg_base,
    input  logic [15:0]           cfg_bursts,
    input  logic                  in_valid,
    input  logic [FSAB_DATA_HI:0] in_data,
    output logic                  in_ready,
    output logic                  dmaw__fsabo_valid,
    output logic [FSAB_REQ_HI:0]  dmaw__fsabo_mode,
    output logic [FSAB_DID_HI:0]  dmaw__fsabo_did,
    output logic [FSAB_DID_HI:0]  dmaw__fsabo_subdid,
    output logic [FSAB_ADDR_HI:0] dmaw__fsabo_addr,
    output logic [FSAB_LEN_HI:0]  dmaw__fsabo_len,
    output logic [FSAB_DATA_HI:0] dmaw__fsabo_data,
    output logic [FSAB_MASK_HI:0] dmaw__fsabo_mask,
    input  logic                  dmaw__fsabo_credit,
    output logic                  wrapped,
    output logic                  overflow
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int ADDR_W = FSAB_ADDR_HI + 1;

    wr_state_t             r_state;
    wr_state_t             w_state_nxt;
    logic [2:0]            r_beat;
    logic [2:0]            r_credits;
    logic [15:0]           r_offset;
    logic                  r_wrapped;
    logic                  r_overflow;

    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic [FSAB_DATA_HI:0] w_head;
    logic                  w_push;
    logic                  w_beat_valid;
    logic                  w_consume;
    logic                  w_last;
    logic                  w_can_start;
    logic [15:0]           w_offset_inc;
    logic                  w_wrap;
    logic [ADDR_W-1:0]     w_addr;

    assign in_ready     = ~w_full;
    assign w_push       = in_valid & in_ready;
    assign w_beat_valid = (r_state == ST_BURST);
    assign w_consume    = w_beat_valid && (r_beat == 3'd0);
    assign w_last       = w_beat_valid && (r_beat == 3'(BURST_LEN - 1));
    assign w_can_start  = cfg_enable && (w_count >= CNT_W'(BURST_LEN)) && (r_credits != 3'd0);
    assign w_offset_inc = r_offset + 16'd1;
    assign w_wrap       = (w_offset_inc >= burst_limit(cfg_bursts));
    // Offset counts 64-byte bursts, so it lands directly above the ignored low bits.
    assign w_addr       = {cfg_base[FSAB_ADDR_HI:6], 6'b0} + ADDR_W'({r_offset, 6'b0});

    fsab_dma_wfifo #(
        .WIDTH (FSAB_DATA_HI + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_wfifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_beat_valid),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_can_start) w_state_nxt = ST_BURST;
            ST_BURST: if (w_last)      w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat     <= 3'd0;
            r_offset   <= 16'd0;
            r_wrapped  <= 1'b0;
            r_overflow <= 1'b0;
            r_credits  <= 3'(FSAB_CREDITS);
        end else begin
            r_wrapped <= 1'b0;
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_beat_valid) begin
                r_beat <= r_beat + 3'd1;
            end else begin
                r_beat <= 3'd0;
            end
            if (w_last) begin
                r_offset  <= w_wrap ? 16'd0 : w_offset_inc;
                r_wrapped <= w_wrap;
            end
            // Simultaneous consume and return cancel out; returns saturate.
            case ({w_consume, dmaw__fsabo_credit})
                2'b10:   r_credits <= r_credits - 3'd1;
                2'b01:   if (r_credits != 3'(FSAB_CREDITS)) r_credits <= r_credits + 3'd1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    credit_return_overflow: assert property (@(posedge clk) disable iff (rst)
        !(dmaw__fsabo_credit && !w_consume && (r_credits == 3'(FSAB_CREDITS))))
        else $warning("fsab_dma_write_ctrl: credit returned with all credits held");

    assign dmaw__fsabo_valid  = w_beat_valid;
    assign dmaw__fsabo_mode   = w_beat_valid ? FSAB_WRITE : '0;
    assign dmaw__fsabo_did    = w_beat_valid ? FSAB_DID : '0;
    assign dmaw__fsabo_subdid = '0;
    assign dmaw__fsabo_addr   = w_beat_valid ? w_addr : '0;
    assign dmaw__fsabo_len    = w_beat_valid ? (FSAB_LEN_HI + 1)'(BURST_LEN) : '0;
    assign dmaw__fsabo_data   = w_beat_valid ? w_head : '0;
    assign dmaw__fsabo_mask   = w_beat_valid ? '1 : '0;
    assign wrapped            = r_wrapped;
    assign overflow           = r_overflow;

endmodule
